// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter:
// the arbiter state encoding and the default sizing constants.
package fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int DEF_DW       = 16;
    localparam int DEF_UW       = 8;
    localparam int DEF_BURST    = 16;
    localparam int DEF_HEADROOM = 4;

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin choice between two requesters.
// With both valid the requester that did not own the last burst wins.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       any,
    output logic       pick
);

    always_comb begin
        any = |valid;
        if (&valid) begin
            pick = ~last;
        end else begin
            pick = valid[1];
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst arbiter feeding one FIFO write port from two valid/ready requesters.
// A grant is issued only when the FIFO has room for a whole burst plus headroom.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int UW       = DEF_UW,
    parameter int BURST    = DEF_BURST,
    parameter int HEADROOM = DEF_HEADROOM
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          fifo_wrreq,
    output logic [DW-1:0] fifo_data,
    input  logic          fifo_wrfull,
    input  logic [UW-1:0] fifo_wrusedw,
    output logic [1:0]    gnt,
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1
);

    localparam int          BW    = $clog2(BURST + 1);
    localparam int unsigned LIMIT = (1 << UW) - BURST - HEADROOM;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic          owner;
    logic          last;
    logic [BW-1:0] beat;
    logic          any_valid;
    logic          pick;
    logic          space_ok;
    logic          owner_valid;
    logic          owner_ready;
    logic [DW-1:0] owner_data;
    logic          transfer;
    logic          burst_done;

    rr_pick2 u_pick (
        .valid ({req1_valid, req0_valid}),
        .last  (last),
        .any   (any_valid),
        .pick  (pick)
    );

    // The used-word count lags our writes, so headroom absorbs the in-flight words.
    assign space_ok    = (32'(fifo_wrusedw) <= LIMIT);
    assign owner_valid = owner ? req1_valid : req0_valid;
    assign owner_data  = owner ? req1_data  : req0_data;
    assign owner_ready = owner ? req1_ready : req0_ready;
    assign transfer    = owner_valid & owner_ready;
    assign burst_done  = transfer & (beat == BW'(BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (any_valid & ~fifo_wrfull & space_ok) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (burst_done | ~owner_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        gnt        = 2'b00;
        if (state == ST_BURST) begin
            req0_ready = ~owner & ~fifo_wrfull;
            req1_ready = owner & ~fifo_wrfull;
            gnt        = owner ? 2'b10 : 2'b01;
        end
    end

    // Ownership, beat count, registered FIFO port and per-requester counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last       <= 1'b1;
            beat       <= '0;
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            fifo_wrreq <= transfer;
            if (transfer) begin
                fifo_data <= owner_data;
                beat      <= beat + BW'(1);
                if (owner) begin
                    cnt1 <= cnt1 + 16'd1;
                end else begin
                    cnt0 <= cnt0 + 16'd1;
                end
            end
            if ((state == ST_IDLE) && (state_nxt == ST_BURST)) begin
                owner <= pick;
                beat  <= '0;
            end else if ((state == ST_BURST) && (state_nxt == ST_IDLE)) begin
                last <= owner;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: a cycle-by-cycle vector table
// followed by hand-written long-burst, stall, early-drop and reset sequences.
module tb_fifo_wr_arb;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        fifo_wrreq;
    logic [15:0] fifo_data;
    logic        fifo_wrfull;
    logic [7:0]  fifo_wrusedw;
    logic [1:0]  gnt;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int checks;
    int failures;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        full;
        logic [7:0]  usedw;
        logic [1:0]  e_rdy;
        logic [1:0]  e_gnt;
        logic        e_wr;
        logic [15:0] e_data;
        logic [15:0] e_cnt0;
        logic [15:0] e_cnt1;
    } vec_t;

    vec_t vecs[14];

    fifo_wr_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .fifo_wrreq   (fifo_wrreq),
        .fifo_data    (fifo_data),
        .fifo_wrfull  (fifo_wrfull),
        .fifo_wrusedw (fifo_wrusedw),
        .gnt          (gnt),
        .cnt0         (cnt0),
        .cnt1         (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v0, input logic v1, input logic [15:0] d0,
                                  input logic [15:0] d1, input logic full, input logic [7:0] usedw);
        req0_valid   = v0;
        req1_valid   = v1;
        req0_data    = d0;
        req1_data    = d1;
        fifo_wrfull  = full;
        fifo_wrusedw = usedw;
    endtask

    task automatic step_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 8'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int i0;
        int i1;
        int k;
        int p;
        int b;
        int exp_g;
        logic exp_burst;
        logic exp_wr;
        logic exp_rdy;
        logic prev_rdy;
        logic full;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b1, 1'b1, 16'hA000, 16'hB000, 1'b0, 8'd241, 2'b00, 2'b00, 1'b0, 16'h0000, 16'd0, 16'd0};
        vecs[1]  = '{1'b1, 1'b1, 16'hA000, 16'hB000, 1'b0, 8'd237, 2'b00, 2'b00, 1'b0, 16'h0000, 16'd0, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 16'hA000, 16'hB000, 1'b0, 8'd236, 2'b00, 2'b00, 1'b0, 16'h0000, 16'd0, 16'd0};
        vecs[3]  = '{1'b1, 1'b1, 16'hA001, 16'hB000, 1'b0, 8'd236, 2'b01, 2'b01, 1'b0, 16'h0000, 16'd0, 16'd0};
        vecs[4]  = '{1'b1, 1'b1, 16'hA002, 16'hB000, 1'b1, 8'd236, 2'b00, 2'b01, 1'b1, 16'hA001, 16'd1, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 16'hA002, 16'hB000, 1'b0, 8'd236, 2'b01, 2'b01, 1'b0, 16'hA001, 16'd1, 16'd0};
        vecs[6]  = '{1'b0, 1'b1, 16'hA003, 16'hB001, 1'b0, 8'd0,   2'b01, 2'b01, 1'b1, 16'hA002, 16'd2, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 16'hA003, 16'hB001, 1'b0, 8'd0,   2'b00, 2'b00, 1'b0, 16'hA002, 16'd2, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 16'hA003, 16'hB001, 1'b0, 8'd0,   2'b10, 2'b10, 1'b0, 16'hA002, 16'd2, 16'd0};
        vecs[9]  = '{1'b0, 1'b0, 16'hA003, 16'hB002, 1'b0, 8'd0,   2'b10, 2'b10, 1'b1, 16'hB001, 16'd2, 16'd1};
        vecs[10] = '{1'b1, 1'b0, 16'hA003, 16'hB002, 1'b1, 8'd0,   2'b00, 2'b00, 1'b0, 16'hB001, 16'd2, 16'd1};
        vecs[11] = '{1'b1, 1'b0, 16'hA003, 16'hB002, 1'b0, 8'd0,   2'b00, 2'b00, 1'b0, 16'hB001, 16'd2, 16'd1};
        vecs[12] = '{1'b0, 1'b0, 16'hA003, 16'hB002, 1'b0, 8'd0,   2'b01, 2'b01, 1'b0, 16'hB001, 16'd2, 16'd1};
        vecs[13] = '{1'b0, 1'b0, 16'hA003, 16'hB002, 1'b0, 8'd0,   2'b00, 2'b00, 1'b0, 16'hB001, 16'd2, 16'd1};

        // Reset values
        do_reset();
        #1;
        check_output("rst_gnt",   32'(gnt), 0);
        check_output("rst_rdy",   32'({req1_ready, req0_ready}), 0);
        check_output("rst_wrreq", 32'(fifo_wrreq), 0);
        check_output("rst_data",  32'(fifo_data), 0);
        check_output("rst_cnt0",  32'(cnt0), 0);
        check_output("rst_cnt1",  32'(cnt1), 0);
        step_clock();

        // Space threshold, stall, early drop and round-robin table
        do_reset();
        for (int v = 0; v < 14; v++) begin
            apply_stimulus(vecs[v].v0, vecs[v].v1, vecs[v].d0, vecs[v].d1, vecs[v].full, vecs[v].usedw);
            #1;
            check_output($sformatf("vec%0d_rdy", v),   32'({req1_ready, req0_ready}), 32'(vecs[v].e_rdy));
            check_output($sformatf("vec%0d_gnt", v),   32'(gnt), 32'(vecs[v].e_gnt));
            check_output($sformatf("vec%0d_wrreq", v), 32'(fifo_wrreq), 32'(vecs[v].e_wr));
            check_output($sformatf("vec%0d_data", v),  32'(fifo_data), 32'(vecs[v].e_data));
            check_output($sformatf("vec%0d_cnt0", v),  32'(cnt0), 32'(vecs[v].e_cnt0));
            check_output($sformatf("vec%0d_cnt1", v),  32'(cnt1), 32'(vecs[v].e_cnt1));
            step_clock();
        end

        // Single requester, 32 words: two bursts of 16 with a one-cycle gap
        do_reset();
        i0 = 0;
        k  = 0;
        for (int c = 0; c <= 36; c++) begin
            apply_stimulus(i0 < 32, 1'b0, 16'(32'h0400 + i0), 16'h0, 1'b0, 8'd0);
            #1;
            exp_burst = (c >= 1 && c <= 16) || (c >= 18 && c <= 33);
            exp_wr    = (c >= 2 && c <= 17) || (c >= 19 && c <= 34);
            check_output($sformatf("solo_gnt_c%0d", c), 32'(gnt), exp_burst ? 1 : 0);
            check_output($sformatf("solo_wrreq_c%0d", c), 32'(fifo_wrreq), 32'(exp_wr));
            if (fifo_wrreq) begin
                check_output($sformatf("solo_data_w%0d", k), 32'(fifo_data), 32'(32'h0400 + k));
                k++;
            end
            if (req0_valid && req0_ready) i0++;
            step_clock();
        end
        check_output("solo_cnt0", 32'(cnt0), 32);
        check_output("solo_words", 32'(k), 32);

        // Both requesters continuously valid: alternating bursts
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int c = 0; c <= 68; c++) begin
            apply_stimulus(1'b1, 1'b1, 16'(32'h1000 + i0), 16'(32'h2000 + i1), 1'b0, 8'd0);
            #1;
            if (c == 0) begin
                exp_g = 0;
            end else begin
                p = (c - 1) % 17;
                b = (c - 1) / 17;
                exp_g = (p == 16) ? 0 : (((b % 2) == 0) ? 1 : 2);
            end
            check_output($sformatf("rr_gnt_c%0d", c), 32'(gnt), 32'(exp_g));
            if (c == 34 || c == 68) begin
                check_output($sformatf("rr_cnt0_c%0d", c), 32'(cnt0), 32'(16 * (c / 34)));
                check_output($sformatf("rr_cnt1_c%0d", c), 32'(cnt1), 32'(16 * (c / 34)));
            end
            if (req0_valid && req0_ready) i0++;
            if (req1_valid && req1_ready) i1++;
            step_clock();
        end

        // FIFO full for three cycles mid-burst
        do_reset();
        i0 = 0;
        k  = 0;
        prev_rdy = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            full = (c >= 6 && c <= 8);
            apply_stimulus(1'b1, 1'b0, 16'(32'h3000 + i0), 16'h0, full, 8'd0);
            #1;
            exp_rdy = (c >= 1 && c <= 19) && !full;
            check_output($sformatf("stall_rdy_c%0d", c), 32'(req0_ready), 32'(exp_rdy));
            check_output($sformatf("stall_wrreq_c%0d", c), 32'(fifo_wrreq), 32'(prev_rdy));
            check_output($sformatf("stall_gnt_c%0d", c), 32'(gnt), (c >= 1 && c <= 19) ? 1 : 0);
            if (fifo_wrreq) k++;
            prev_rdy = exp_rdy;
            if (req0_valid && req0_ready) i0++;
            step_clock();
        end
        check_output("stall_cnt0", 32'(cnt0), 16);
        check_output("stall_words", 32'(k), 16);

        // Owner drops valid after 5 words, then the other requester wins
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            apply_stimulus(c != 6, 1'b1, 16'(32'h4000 + c), 16'(32'h5000 + c), 1'b0, 8'd0);
            #1;
            if (c == 5 || c == 6) check_output($sformatf("drop_gnt_c%0d", c), 32'(gnt), 1);
            if (c == 7) begin
                check_output("drop_gnt_c7", 32'(gnt), 0);
                check_output("drop_cnt0", 32'(cnt0), 5);
                check_output("drop_wrreq_c7", 32'(fifo_wrreq), 0);
            end
            if (c == 8) begin
                check_output("drop_gnt_c8", 32'(gnt), 2);
                check_output("drop_rdy_c8", 32'({req1_ready, req0_ready}), 2);
            end
            step_clock();
        end
        apply_stimulus(1'b1, 1'b1, 16'h4009, 16'h5009, 1'b0, 8'd0);
        #1;
        check_output("pre_rst_gnt",  32'(gnt), 2);
        check_output("pre_rst_data", 32'(fifo_data), 32'h5008);
        check_output("pre_rst_cnt1", 32'(cnt1), 1);

        // Asynchronous reset in the middle of requester 1's burst
        #1;
        rst_n = 1'b0;
        #1;
        check_output("arst_gnt",   32'(gnt), 0);
        check_output("arst_rdy",   32'({req1_ready, req0_ready}), 0);
        check_output("arst_wrreq", 32'(fifo_wrreq), 0);
        check_output("arst_data",  32'(fifo_data), 0);
        check_output("arst_cnt0",  32'(cnt0), 0);
        check_output("arst_cnt1",  32'(cnt1), 0);
        repeat (2) @(posedge clk);
        #1;
        check_output("arst_hold_gnt",   32'(gnt), 0);
        check_output("arst_hold_wrreq", 32'(fifo_wrreq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("rel_gnt_idle", 32'(gnt), 0);
        step_clock();
        check_output("rel_gnt_first", 32'(gnt), 1);
        check_output("rel_rdy_first", 32'({req1_ready, req0_ready}), 1);
        check_output("rel_wrreq",     32'(fifo_wrreq), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
